// File: rtl/dds_wavegen_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : dds_wavegen_if                                             |
// | Description : Control and sample bundle for the DDS waveform generator.  |
// |               The master side drives en/load/mode/fcw and receives the   |
// |               sample stream (out, out_valid, wrap). The slave side is    |
// |               the generator itself.                                      |
// |   en        : advance the phase and produce a sample this cycle          |
// |   load      : synchronous phase clear, priority over en                  |
// |   mode      : 0 saw, 1 square, 2 triangle, 3 sine                        |
// |   fcw       : frequency control word (phase increment)                   |
// |   out       : unsigned offset-binary sample                              |
// |   out_valid : out was updated on the last edge                           |
// |   wrap      : accumulator overflowed on the last edge                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface dds_wavegen_if #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
);
  logic               en;
  logic               load;
  logic [1:0]         mode;
  logic [PHASE_W-1:0] fcw;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               wrap;

  modport master (
    output en,
    output load,
    output mode,
    output fcw,
    input  out,
    input  out_valid,
    input  wrap
  );

  modport slave (
    input  en,
    input  load,
    input  mode,
    input  fcw,
    output out,
    output out_valid,
    output wrap
  );
endinterface
`default_nettype wire

// File: rtl/dds_wavegen.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : dds_wavegen                                                |
// | Description : Direct-digital-synthesis waveform generator. A phase       |
// |               accumulator stepped by a shadowed frequency control word   |
// |               feeds a registered waveform decoder (saw, square,          |
// |               triangle, quarter-wave LUT sine). Frequency and mode       |
// |               changes are accepted only at phase wrap or while idle so   |
// |               a period is never cut short.                               |
// | Ports       : clk    - clock, rising edge                                |
// |               rst_n  - asynchronous active-low reset                     |
// |               bus    - dds_wavegen_if.slave (en, load, mode, fcw in;     |
// |                        out, out_valid, wrap out)                         |
// | Parameters  : PHASE_W - accumulator width (>= 6, nominally >= OUT_W+1)   |
// |               OUT_W   - output sample width (>= 8)                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dds_wavegen #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  dds_wavegen_if.slave bus
);

  localparam logic [1:0] c_MODE_SAW = 2'd0;
  localparam logic [1:0] c_MODE_SQR = 2'd1;
  localparam logic [1:0] c_MODE_TRI = 2'd2;
  localparam logic [1:0] c_MODE_SIN = 2'd3;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_fcw_act;
  logic [1:0]         r_mode_act;
  logic [OUT_W-1:0]   r_out;
  logic               r_out_valid;
  logic               r_wrap;

  // ---------------------------------------------------------------------
  // Phase step: the extra top bit is the overflow carry.
  // ---------------------------------------------------------------------
  logic [PHASE_W:0] w_sum;
  logic             w_carry;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_fcw_act};
  assign w_carry = w_sum[PHASE_W];

  // ---------------------------------------------------------------------
  // Waveform decode from the pre-update phase.
  // Saw and triangle are taken from a zero-padded copy of the phase so the
  // slices stay in range even when the accumulator is not wider than the
  // output.
  // ---------------------------------------------------------------------
  logic             w_msb;
  logic [OUT_W-1:0] w_saw;
  logic [OUT_W-1:0] w_sqr;
  logic [OUT_W-1:0] w_tri_t;
  logic [OUT_W-1:0] w_tri;

  assign w_msb   = r_acc[PHASE_W-1];
  assign w_saw   = OUT_W'({r_acc, {OUT_W{1'b0}}} >> PHASE_W);
  assign w_sqr   = w_msb ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
  assign w_tri_t = OUT_W'({r_acc[PHASE_W-2:0], {OUT_W{1'b0}}} >> (PHASE_W - 1));
  assign w_tri   = w_msb ? ~w_tri_t : w_tri_t;

  // Sine: top two phase bits pick the quadrant, next four index a 16-entry
  // quarter-wave table. Odd quadrants run the table backwards, the upper
  // half-period is mirrored below mid-scale (128).
  logic [1:0]       w_q;
  logic [3:0]       w_i;
  logic [3:0]       w_j;
  logic [6:0]       w_m;
  logic [7:0]       w_s8;
  logic [OUT_W-1:0] w_sin;

  assign w_q = r_acc[PHASE_W-1 -: 2];
  assign w_i = r_acc[PHASE_W-3 -: 4];
  assign w_j = w_q[0] ? (4'd15 - w_i) : w_i;

  // round(127 * sin((2j+1)*pi/64)); half-step offset keeps the table
  // symmetric so no quadrant repeats an endpoint.
  always_comb begin
    w_m = 7'd0;
    case (w_j)
      4'd0:  w_m = 7'd6;
      4'd1:  w_m = 7'd19;
      4'd2:  w_m = 7'd31;
      4'd3:  w_m = 7'd43;
      4'd4:  w_m = 7'd54;
      4'd5:  w_m = 7'd65;
      4'd6:  w_m = 7'd76;
      4'd7:  w_m = 7'd85;
      4'd8:  w_m = 7'd94;
      4'd9:  w_m = 7'd102;
      4'd10: w_m = 7'd109;
      4'd11: w_m = 7'd115;
      4'd12: w_m = 7'd120;
      4'd13: w_m = 7'd123;
      4'd14: w_m = 7'd126;
      4'd15: w_m = 7'd127;
      default: w_m = 7'd0;
    endcase
  end

  assign w_s8  = w_q[1] ? (8'd128 - {1'b0, w_m}) : (8'd128 + {1'b0, w_m});
  // Left-justify the 8-bit sine into OUT_W bits, low bits zero.
  assign w_sin = OUT_W'({w_s8, {OUT_W{1'b0}}} >> 8);

  logic [OUT_W-1:0] w_wave;

  always_comb begin
    w_wave = w_saw;
    case (r_mode_act)
      c_MODE_SAW: w_wave = w_saw;
      c_MODE_SQR: w_wave = w_sqr;
      c_MODE_TRI: w_wave = w_tri;
      c_MODE_SIN: w_wave = w_sin;
      default:    w_wave = w_saw;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_fcw_act   <= '0;
      r_mode_act  <= 2'd0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else if (bus.load) begin
      // Phase restart; out holds its last sample.
      r_acc       <= '0;
      r_fcw_act   <= bus.fcw;
      r_mode_act  <= bus.mode;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else if (bus.en) begin
      r_acc       <= w_sum[PHASE_W-1:0];
      r_out       <= w_wave;
      r_out_valid <= 1'b1;
      r_wrap      <= w_carry;
      // New settings only at a period boundary so the waveform never glitches.
      if (w_carry) begin
        r_fcw_act  <= bus.fcw;
        r_mode_act <= bus.mode;
      end
    end else begin
      // Idle: nothing is being emitted, so settings track the inputs freely.
      r_fcw_act   <= bus.fcw;
      r_mode_act  <= bus.mode;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_dds_wavegen.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_dds_wavegen                                             |
// | Description : Self-checking bench for dds_wavegen. Two instances: an     |
// |               8-bit-phase one for saw/square/sine/load/reset scenarios   |
// |               and a 9-bit-phase one for the triangle. Expected samples   |
// |               are queued as stimulus is driven and compared whenever the |
// |               DUT flags out_valid (-1 entries are popped unchecked).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dds_wavegen;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dds_wavegen_if #(.PHASE_W(8), .OUT_W(8)) bus_a ();
  dds_wavegen_if #(.PHASE_W(9), .OUT_W(8)) bus_b ();

  dds_wavegen #(.PHASE_W(8), .OUT_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  dds_wavegen #(.PHASE_W(9), .OUT_W(8)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_a[$];
  int exp_b[$];
  int e_a;
  int e_b;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_a.out_valid === 1'b1) begin
      if (exp_a.size() == 0) begin
        check_val("a_unexpected_valid", bus_a.out_valid, 0);
      end else begin
        e_a = exp_a.pop_front();
        if (e_a >= 0) check_val("a_out", bus_a.out, e_a);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_b.out_valid === 1'b1) begin
      if (exp_b.size() == 0) begin
        check_val("b_unexpected_valid", bus_b.out_valid, 0);
      end else begin
        e_b = exp_b.pop_front();
        if (e_b >= 0) check_val("b_out", bus_b.out, e_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  int tri_tbl[8];
  int sq_tbl[9];
  int a_sin;

  initial begin
    tri_tbl = '{0, 64, 128, 192, 255, 191, 127, 63};
    sq_tbl  = '{96, 128, 160, 192, 224, 255, 255, 0, 0};

    rst_n = 1'b0;
    bus_a.en = 1'b0; bus_a.load = 1'b0; bus_a.mode = 2'd0; bus_a.fcw = '0;
    bus_b.en = 1'b0; bus_b.load = 1'b0; bus_b.mode = 2'd0; bus_b.fcw = '0;
    repeat (3) @(negedge clk);
    check_val("rst_out",   bus_a.out, 0);
    check_val("rst_valid", bus_a.out_valid, 0);
    check_val("rst_wrap",  bus_a.wrap, 0);

    // Idle cycles latch the shadow settings.
    rst_n = 1'b1;
    bus_a.mode = 2'd0; bus_a.fcw = 8'd32;
    bus_b.mode = 2'd2; bus_b.fcw = 9'd64;
    repeat (2) @(negedge clk);
    check_val("idle_valid", bus_a.out_valid, 0);

    // Triangle, 9-bit phase, step 64
    for (int k = 0; k < 16; k++) begin
      bus_b.en = 1'b1;
      exp_b.push_back(tri_tbl[k % 8]);
      @(negedge clk);
      check_val("tri_wrap", bus_b.wrap, ((k + 1) % 8 == 0) ? 1 : 0);
    end
    bus_b.en = 1'b0;
    @(negedge clk);
    check_val("tri_idle_valid", bus_b.out_valid, 0);

    // Saw, 8-bit phase, step 32: 11 samples leaves acc at 96
    for (int k = 0; k < 11; k++) begin
      bus_a.en = 1'b1;
      exp_a.push_back((k * 32) % 256);
      @(negedge clk);
      if (k == 0) check_val("saw_valid_rise", bus_a.out_valid, 1);
      check_val("saw_wrap", bus_a.wrap, ((k + 1) % 8 == 0) ? 1 : 0);
    end

    // Change to square / step 64 mid-period: takes effect only after wrap
    bus_a.mode = 2'd1; bus_a.fcw = 8'd64;
    for (int k = 0; k < 9; k++) begin
      exp_a.push_back(sq_tbl[k]);
      @(negedge clk);
      check_val("shadow_wrap", bus_a.wrap, (k == 4 || k == 8) ? 1 : 0);
    end

    // Back to saw via idle, then load to zero the phase
    bus_a.en = 1'b0; bus_a.mode = 2'd0; bus_a.fcw = 8'd32;
    @(negedge clk);
    check_val("idle2_valid", bus_a.out_valid, 0);
    check_val("idle2_wrap",  bus_a.wrap, 0);
    bus_a.load = 1'b1;
    @(negedge clk);
    check_val("load_valid", bus_a.out_valid, 0);
    bus_a.load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus_a.en = 1'b1;
      exp_a.push_back(k * 32);
      @(negedge clk);
    end
    // acc = 160: load together with en wins
    bus_a.load = 1'b1;
    @(negedge clk);
    check_val("load_en_valid", bus_a.out_valid, 0);
    check_val("load_en_wrap",  bus_a.wrap, 0);
    check_val("load_en_hold",  bus_a.out, 128);
    bus_a.load = 1'b0;
    exp_a.push_back(0);
    @(negedge clk);
    check_val("post_load_wrap", bus_a.wrap, 0);
    exp_a.push_back(32);
    @(negedge clk);
    bus_a.en = 1'b0;

    // Sine, step 4, from phase 0
    bus_a.mode = 2'd3; bus_a.fcw = 8'd4;
    @(negedge clk);
    bus_a.load = 1'b1;
    @(negedge clk);
    bus_a.load = 1'b0;
    for (int k = 0; k < 48; k++) begin
      case (k * 4)
        0:       a_sin = 134;
        4:       a_sin = 147;
        8:       a_sin = 159;
        60:      a_sin = 255;
        64:      a_sin = 255;
        128:     a_sin = 122;
        188:     a_sin = 1;
        default: a_sin = -1;
      endcase
      bus_a.en = 1'b1;
      exp_a.push_back(a_sin);
      @(negedge clk);
    end
    bus_a.en = 1'b0;

    // fcw = 0: phase frozen at 192, sine sample 1 repeats, never wraps
    bus_a.fcw = 8'd0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus_a.en = 1'b1;
      exp_a.push_back(1);
      @(negedge clk);
      check_val("fcw0_wrap", bus_a.wrap, 0);
    end
    bus_a.en = 1'b0;

    // Reach out = 224 with saw, then asynchronous reset mid-cycle
    bus_a.mode = 2'd0; bus_a.fcw = 8'd32;
    @(negedge clk);
    bus_a.load = 1'b1;
    @(negedge clk);
    bus_a.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus_a.en = 1'b1;
      exp_a.push_back(k * 32);
      @(negedge clk);
    end
    check_val("pre_rst_wrap", bus_a.wrap, 1);
    #2;
    bus_a.en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_out",   bus_a.out, 0);
    check_val("async_rst_valid", bus_a.out_valid, 0);
    check_val("async_rst_wrap",  bus_a.wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.mode = 2'd3;
    repeat (2) @(negedge clk);
    check_val("post_rst_out",   bus_a.out, 0);
    check_val("post_rst_valid", bus_a.out_valid, 0);
    check_val("post_rst_wrap",  bus_a.wrap, 0);
    // First sample after reset is wave(sine, 0)
    bus_a.en = 1'b1;
    exp_a.push_back(134);
    @(negedge clk);
    bus_a.en = 1'b0;
    @(negedge clk);

    check_val("a_queue_drained", exp_a.size(), 0);
    check_val("b_queue_drained", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_wavegen.md
# dds_wavegen

- Parametrised direct-digital-synthesis waveform generator.
- Phase accumulator stepped by a frequency control word, followed by a registered case-based waveform decoder.
- Four waveforms: sawtooth, square, triangle, quarter-wave-LUT sine.
- Frequency and mode changes are shadowed and take effect only at phase wrap or while idle, so the output has no mid-period glitches. It sits upstream of the DAC or check-logic path as the codebase's numeric signal source.

## Interface
- PHASE_W, 16: accumulator width. Must be at least OUT_W+1 and at least 6.
- OUT_W, 8: output sample width. Must be at least 8.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance the phase and produce a sample this cycle.
- load  input  1  synchronous phase clear; has priority over en.
- mode  input  2  0 saw, 1 square, 2 triangle, 3 sine.
- fcw  input  PHASE_W  frequency control word (phase increment).
- out  output  OUT_W  unsigned, offset-binary sample.
- out_valid  output  1  out was updated on the last edge.
- wrap  output  1  one-cycle pulse; the accumulator overflowed on the last edge.

## Operation
- **State:**
  - acc[PHASE_W].
  - fcw_act[PHASE_W] and mode_act[2] (shadow registers).
  - out, out_valid, wrap registers.
- **Reset (rst_n=0, asynchronous):** all state and outputs are 0.
- **load=1:**
  - acc <= 0.
  - fcw_act <= fcw, mode_act <= mode.
  - out_valid <= 0, wrap <= 0; out holds.
- **en=0, load=0:**
  - acc and out hold.
  - fcw_act <= fcw, mode_act <= mode every cycle.
  - out_valid <= 0, wrap <= 0.
- **en=1, load=0:**
  - {carry, acc} <= acc + fcw_act. Result is modulo 2^PHASE_W.
  - out <= wave(mode_act, acc), using the pre-update acc and mode_act.
  - out_valid <= 1, wrap <= carry.
  - If carry=1, fcw_act <= fcw and mode_act <= mode on the same edge. Otherwise they hold.
- **wave(), with M = acc MSB:**
  - Saw: acc[PHASE_W-1 -: OUT_W].
  - Square: M ? 0 : all-ones.
  - Triangle: t = acc[PHASE_W-2 -: OUT_W]; result is M ? ~t : t.
  - Sine, intermediate values:
    - q = acc[PHASE_W-1 -: 2].
    - i = acc[PHASE_W-3 -: 4].
    - j = q[0] ? 15-i : i.
    - m = LUT[j].
    - s8 = q[1] ? 128-m : 128+m.
  - Sine result: s8 << (OUT_W-8), with the low bits 0.
- **LUT** (7-bit, round(127·sin((2j+1)π/64))), index 0..15: 6, 19, 31, 43, 54, 65, 76, 85, 94, 102, 109, 115, 120, 123, 126, 127.
- **fcw edge cases:**
  - fcw_act=0 with en=1: acc is constant and samples repeat; there is never a wrap, so shadows never update until en drops or load.
  - fcw_act=2^PHASE_W-1 is legal: acc decrements effectively and wraps every cycle except from 0.

## Timing
- Latency: the sample for phase value acc(n) appears on out one edge after the cycle in which acc = acc(n).
- out_valid is en delayed one cycle, masked by load.
- wrap is asserted the cycle acc holds the post-overflow value. The first sample using the new mode/fcw appears the cycle after wrap.
- load and en both high: load wins, no step.
- rst_n asserted mid-run clears everything immediately. After release, the first en cycle yields out = wave(mode, 0) one edge later.

## Test plan
- **Reset:** rst_n=0 mid-run with out=0xE0 -> out, out_valid and wrap go 0 without a clock edge. Release with en=0 -> all stay 0.
- **Saw** (PHASE_W=8, fcw=32, mode 0, en held from acc=0):
  - out = 0, 32, 64, …, 224, 0, …
  - out_valid rises 1 cycle after en.
  - wrap pulses once every 8 cycles, the cycle acc returns to 0.
- **Sine** (PHASE_W=8, fcw=4, mode 3):
  - Samples for acc = 0, 4, 8 -> 134, 147, 159.
  - acc = 60 -> 255; acc = 64 -> 255.
  - acc = 128 -> 122; acc = 188 -> 1.
- **Shadowed change** (saw, fcw=32, change mode to 1 and fcw to 64 while acc=96):
  - out continues 96, 128, 160, 192, 224.
  - After wrap: 255, 255, 0, 0 with step 64.
- **Triangle** (PHASE_W=9, fcw=64, mode 2) -> out = 0, 64, 128, 192, 255, 191, 127, 63, repeating.
- **load** asserted at acc=160 together with en -> acc becomes 0, out_valid 0 for that cycle, no wrap. The next en cycle samples phase 0.
